dino_jump_ctrl: RTL



---
 rtl/dino_pkg.sv | 20 ++
 rtl/dino_tick_gen.sv | 30 +++
 rtl/dino_jump_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Shared types and defaults for the dino jump controller and its integrator.
// Build with DEBOUNCE_EN defined to debounce the buttons.
package dino_pkg;

  typedef logic signed [31:0] kin_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    LAUNCH = 3'd2,
    AIR    = 3'd3,
    LAND   = 3'd4,
    DEAD   = 3'd5
  } state_t;

  localparam kin_t DEF_GRAV_NORM  = 32'sd1;
  localparam kin_t DEF_GRAV_FAST  = 32'sd2;
  localparam kin_t DEF_LAUNCH_VEL = 32'sd1200;

endpackage

// File: rtl/dino_tick_gen.sv
// Physics tick divider: counts 0..TICK_DIV-1, wraps, and restarts on clr.
// The tick is masked while clr is high so a restart never double-ticks.
module dino_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en & ~clr & (cnt == '0);

endmodule

// File: rtl/dino_jump_ctrl.sv
// Game/jump sequencer driving the dino physics integrator.
// Optional DEBOUNCE_EN adds a stability filter behind the synchronizers.
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter int   TICK_DIV   = 100000,
  parameter kin_t LAUNCH_VEL = DEF_LAUNCH_VEL,
  parameter kin_t GRAV_NORM  = DEF_GRAV_NORM,
  parameter kin_t GRAV_FAST  = DEF_GRAV_FAST,
  parameter int   SCORE_W    = 16
`ifdef DEBOUNCE_EN
  ,
  parameter int   DEB_CYCLES = 1000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               collide,
  input  kin_t               pos,
  input  kin_t               vel,
  output logic               phys_tick,
  output logic               phys_load,
  output logic               phys_clear,
  output kin_t               load_vel,
  output kin_t               acc,
  output logic [2:0]         game_state,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] lvl;
  logic       up_q;
  logic       up_edge;
  logic       down_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_down, btn_up};
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt [2];
  logic [1:0]    deb;

  // Level follows the synced input only after a full stable window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb        <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DLAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = deb;
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q <= 1'b0;
    end else begin
      up_q <= lvl[0];
    end
  end

  assign up_edge  = lvl[0] & ~up_q;
  assign down_lvl = lvl[1];

  state_t state_q;
  state_t state_d;
  logic   tick;
  logic   run_entry_q;
  logic   landed;

  dino_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == RUN || state_q == AIR),
    .clr  (run_entry_q),
    .tick (tick)
  );

  // Landing is judged only between ticks so pos/vel are settled.
  assign landed = (pos <= 0) && (vel <= 0) && !tick;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (up_edge) state_d = RUN;
      RUN: begin
        if (collide)      state_d = DEAD;
        else if (up_edge) state_d = LAUNCH;
      end
      LAUNCH:  state_d = AIR;
      AIR: begin
        if (collide)     state_d = DEAD;
        else if (landed) state_d = LAND;
      end
      LAND:    state_d = RUN;
      DEAD:    if (up_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_entry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_entry_q <= (state_d == RUN) && (state_q != RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (state_d == LAUNCH) begin
      acc <= -GRAV_NORM;
    end else if (state_d == LAND || (state_q == DEAD && up_edge)) begin
      acc <= '0;
    end else if (state_q == AIR && tick) begin
      acc <= down_lvl ? -GRAV_FAST : -GRAV_NORM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score <= '0;
    end else if (state_q == DEAD && up_edge) begin
      score <= '0;
    end else if (tick && score != '1) begin
      score <= score + 1'b1;
    end
  end

  assign phys_tick  = tick;
  assign phys_load  = (state_q == LAUNCH);
  assign phys_clear = (state_q == LAND) || (state_q == DEAD && up_edge);
  assign load_vel   = phys_load ? LAUNCH_VEL : '0;
  assign game_state = state_q;
  assign game_over  = (state_q == DEAD);

endmodule
